fetch_unit: RTL

Instruction fetch stage of the RISC-V CPU. Holds the program counter, issues word fetches to instruction memory over a request/response handshake, and presents each fetched instruction with its PC to the decoder through a one-entry valid/ready output register. Sits directly upstream of `decoder`. Branch and jump redirects from execute retarget the PC and squash any in-flight or buffered instruction.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, fetches one word at a
// time from instruction memory (request/response, at most one outstanding)
// and hands each instruction with its PC to the decoder through a one-entry
// valid/ready output register. Execute redirects retarget the PC and squash
// any in-flight or buffered instruction.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap redirects whose
// target is not word aligned (sticky fault_out, fetch halts until rst).
// Without it the target's low two bits are simply forced to zero.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ready_in,
   input  logic        imem_rvalid_in,
   input  logic [31:0] imem_rdata_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid_out,
   input  logic        decode_ready_in,
   output logic        fault_out
);

   typedef enum logic [2:0] {
      S_RESET,
      S_REQ,
      S_WAIT,
      S_WAIT_DISCARD,
      S_FAULT
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;

   logic        out_free;
   logic        req_acc;
   logic        redir_take;
   logic        redir_bad;
   logic [31:0] redir_tgt;
   logic        rsp_take;

   // The output slot can take a new instruction if it is empty or being drained.
   assign out_free   = !instr_valid_out || decode_ready_in;
   assign req_acc    = imem_req_out && imem_ready_in;
   // Redirects are ignored while coming out of reset and once faulted.
   assign redir_take = redirect_in && (state != S_RESET) && (state != S_FAULT);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redir_bad  = redir_take && (redirect_pc_in[1:0] != 2'b00);
   assign redir_tgt  = redirect_pc_in;
`else
   logic unused_redir_lsb;
   assign unused_redir_lsb = ^redirect_pc_in[1:0];
   assign redir_bad  = 1'b0;
   assign redir_tgt  = {redirect_pc_in[31:2], 2'b00};
`endif

   // A response is kept only when it answers a live (non-squashed) request.
   assign rsp_take   = (state == S_WAIT) && imem_rvalid_in && !redir_take;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a redirect pre-empts normal sequencing.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET: begin
            state_nxt = S_REQ;
         end
         S_REQ: begin
            if (redir_bad) begin
               state_nxt = S_FAULT;
            end else if (req_acc) begin
               // A request leaving in the redirect cycle targets the old PC.
               state_nxt = redir_take ? S_WAIT_DISCARD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (redir_bad) begin
               state_nxt = S_FAULT;
            end else if (imem_rvalid_in) begin
               state_nxt = S_REQ;
            end else if (redir_take) begin
               state_nxt = S_WAIT_DISCARD;
            end
         end
         S_WAIT_DISCARD: begin
            if (redir_bad) begin
               state_nxt = S_FAULT;
            end else if (imem_rvalid_in) begin
               state_nxt = S_REQ;
            end
         end
         S_FAULT: begin
            state_nxt = S_FAULT;
         end
         default: begin
            state_nxt = S_RESET;
         end
      endcase
   end

   // Memory-side outputs: request only when the output slot can absorb the reply.
   always_comb begin
      imem_req_out  = (state == S_REQ) && out_free;
      imem_addr_out = pc;
   end

   // Program counter: redirect target, else advance past each kept response.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redir_take && !redir_bad) begin
         pc <= redir_tgt;
      end else if (rsp_take) begin
         pc <= pc + 32'd4;
      end
   end

   // Output register to the decoder; a redirect empties it.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out       <= 32'h0000_0000;
         pc_out          <= RESET_PC;
         instr_valid_out <= 1'b0;
      end else if (redir_take) begin
         instr_valid_out <= 1'b0;
      end else if (rsp_take) begin
         instr_out       <= imem_rdata_in;
         pc_out          <= pc;
         instr_valid_out <= 1'b1;
      end else if (instr_valid_out && decode_ready_in) begin
         instr_valid_out <= 1'b0;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Sticky misaligned-redirect fault, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_out <= 1'b0;
      end else if (redir_bad) begin
         fault_out <= 1'b1;
      end
   end
`else
   assign fault_out = 1'b0;
`endif

endmodule
